// File: rtl/ddr_rx_deser.sv
// DDR receive deserialiser: hunts for a sync sample on either lane, then packs
// payload samples in time order into 2*RATIO-sample words behind a valid/ready port.
module ddr_rx_deser #(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           RATIO        = 4,
  parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = DATA_WIDTH'(8'hA5),
  parameter int unsigned           OUT_WIDTH    = 2 * RATIO * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] rise_data,
  input  logic [DATA_WIDTH-1:0] fall_data,
  input  logic                  realign,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  locked,
  output logic                  phase,
  output logic                  overflow
);

  localparam int unsigned NS = 2 * RATIO;
  localparam int unsigned CW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {
    S_HUNT   = 1'b0,
    S_LOCKED = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   asm_q, asm_d;
  logic [OUT_WIDTH-1:0]   odata_q, odata_d;
  logic                   ovalid_q, ovalid_d;
  logic                   phase_q, phase_d;
  logic                   ovf_q, ovf_d;

  logic [CW-1:0]          pos1_c;
  logic [OUT_WIDTH-1:0]   word_c;
  logic                   comp_c;
  logic                   hs_c;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_HUNT;
      cnt_q    <= '0;
      asm_q    <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      phase_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      asm_q    <= asm_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      phase_q  <= phase_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state, assembly and output handshake logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    asm_d    = asm_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    phase_d  = phase_q;
    ovf_d    = ovf_q;
    comp_c   = 1'b0;
    hs_c     = ovalid_q && out_ready;
    pos1_c   = (cnt_q == CW'(NS - 1)) ? '0 : CW'(cnt_q + CW'(1));

    // Completed word sees the fall sample only if it does not wrap into the next word
    word_c = asm_q;
    word_c[32'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] = rise_data;
    if (pos1_c != '0) begin
      word_c[32'(pos1_c) * DATA_WIDTH +: DATA_WIDTH] = fall_data;
    end

    if (realign) begin
      state_d = S_HUNT;
      cnt_d   = '0;
      asm_d   = '0;
      phase_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_HUNT: begin
          if (in_valid) begin
            if (rise_data == SYNC_PATTERN) begin
              state_d                  = S_LOCKED;
              phase_d                  = 1'b1;
              asm_d[DATA_WIDTH-1:0]    = fall_data;
              cnt_d                    = CW'(1);
            end else if (fall_data == SYNC_PATTERN) begin
              state_d = S_LOCKED;
              phase_d = 1'b0;
              cnt_d   = '0;
            end
          end
        end
        S_LOCKED: begin
          if (in_valid) begin
            asm_d = word_c;
            asm_d[32'(pos1_c) * DATA_WIDTH +: DATA_WIDTH] = fall_data;
            comp_c = (cnt_q == CW'(NS - 1)) || (pos1_c == CW'(NS - 1));
            if (pos1_c == CW'(NS - 1)) begin
              cnt_d = '0;
            end else if (cnt_q == CW'(NS - 1)) begin
              cnt_d = CW'(1);
            end else begin
              cnt_d = CW'(cnt_q + CW'(2));
            end
          end
        end
        default: state_d = S_HUNT;
      endcase
    end

    if (comp_c) begin
      if (!ovalid_q || hs_c) begin
        odata_d  = word_c;
        ovalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end else if (hs_c) begin
      ovalid_d = 1'b0;
    end
  end

  assign out_valid = ovalid_q;
  assign out_data  = odata_q;
  assign locked    = (state_q == S_LOCKED);
  assign phase     = phase_q;
  assign overflow  = ovf_q;

endmodule
